// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues the PC to synchronous imem, tracks the single
// in-flight read and buffers {pc, inst} pairs as the IF/ID register.
module if_fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  input  logic        stall_id,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus4
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pend_v;
  logic [31:0]   pend_pc;

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ;
  logic [CW:0]   limit;

  assign id_valid = (count != '0);
  assign pop      = id_valid & ~stall_id & ~flush;
  assign push     = pend_v & ~flush;

  // Credit check: slots committed (buffered + in flight) after this cycle's pop.
  assign occ      = {1'b0, count} + (CW+1)'(pend_v);
  assign limit    = (CW+1)'(DEPTH) + (CW+1)'(pop);
  assign issue    = ~flush & (occ < limit);

  assign imem_req  = rst & issue;
  assign imem_addr = pc_in;
  assign pc_stall  = rst & ~issue & ~flush;

  assign id_pc       = id_valid ? mem_pc[rd_ptr]   : 32'd0;
  assign id_inst     = id_valid ? mem_inst[rd_ptr] : NOP_INST;
  assign id_pc_plus4 = id_pc + 32'd4;

  // Control state: flush wins over push, pop and issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pend_v  <= 1'b0;
      pend_pc <= 32'd0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pend_v  <= 1'b0;
    end else begin
      pend_v <= issue;
      if (issue) pend_pc <= pc_in;
      if (push)  wr_ptr  <= wr_ptr + 1'b1;
      if (pop)   rd_ptr  <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage carries no reset; the output mux hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= pend_pc;
      mem_inst[wr_ptr] <= imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_if_fetch_queue;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        stall_id;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc_plus4;

  int checks   = 0;
  int failures = 0;

  // Reference model: buffered entries, in-flight read, PC register, target.
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] target;

  if_fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_stall(pc_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .flush(flush), .stall_id(stall_id), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .id_pc_plus4(id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'h100;
  endfunction

  // One clock cycle: compare outputs before the edge, then advance the model.
  task automatic tick();
    logic        e_valid, e_pop, e_issue, e_stall;
    logic [31:0] e_pc, e_inst, old_pc;
    #1;
    if (!rst) begin
      e_valid = 1'b0; e_pc = 32'd0; e_inst = NOP;
      e_pop = 1'b0; e_issue = 1'b0; e_stall = 1'b0;
    end else begin
      e_valid = (q_pc.size() != 0);
      e_pc    = e_valid ? q_pc[0]   : 32'd0;
      e_inst  = e_valid ? q_inst[0] : NOP;
      e_pop   = e_valid && !stall_id && !flush;
      e_issue = !flush && ((q_pc.size() + int'(m_pend) - int'(e_pop)) < DEPTH);
      e_stall = !e_issue && !flush;
    end
    chk("id_valid", 32'(id_valid), 32'(e_valid));
    chk("id_pc", id_pc, e_pc);
    chk("id_inst", id_inst, e_inst);
    chk("id_pc_plus4", id_pc_plus4, e_pc + 32'd4);
    chk("imem_req", 32'(imem_req), 32'(e_issue));
    chk("pc_stall", 32'(pc_stall), 32'(e_stall));
    if (e_issue) chk("imem_addr", imem_addr, pc_in);
    @(posedge clk);
    #1;
    old_pc = pc_in;
    if (!rst) begin
      q_pc.delete(); q_inst.delete();
      m_pend = 1'b0; pc_in = 32'd0; imem_rdata = $urandom;
    end else if (flush) begin
      q_pc.delete(); q_inst.delete();
      m_pend = 1'b0; pc_in = target; imem_rdata = $urandom;
    end else begin
      if (e_pop) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (m_pend) begin
        q_pc.push_back(m_pend_pc);
        q_inst.push_back(imem_rdata);
      end
      m_pend = e_issue;
      if (e_issue) m_pend_pc = old_pc;
      imem_rdata = e_issue ? mem_word(old_pc) : $urandom;
      if (!e_stall) pc_in = old_pc + 32'd4;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, 32'(id_valid), 32'd1);
    chk({name, "_pc"}, id_pc, pc);
    chk({name, "_inst"}, id_inst, mem_word(pc));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valid"}, 32'(id_valid), 32'd0);
    chk({name, "_inst"}, id_inst, NOP);
    chk({name, "_pc"}, id_pc, 32'd0);
    chk({name, "_plus4"}, id_pc_plus4, 32'd4);
    chk({name, "_req"}, 32'(imem_req), 32'd0);
    chk({name, "_stall"}, 32'(pc_stall), 32'd0);
  endtask

  initial begin
    rst = 1'b0; pc_in = 32'd0; flush = 1'b0; stall_id = 1'b0;
    target = 32'd0; imem_rdata = $urandom;
    m_pend = 1'b0; m_pend_pc = 32'd0;
    @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    ticks(3);

    // Release; first edge issues PC 0, next edge makes it the head.
    rst = 1'b1;
    ticks(2);
    chk_head("first", 32'h0);
    ticks(3);
    chk_head("steady", 32'hC);

    // Flush with 0x10 in flight and one buffered entry.
    flush = 1'b1; target = 32'h40;
    #1;
    chk("flush_pc_stall", 32'(pc_stall), 32'd0);
    chk("flush_req", 32'(imem_req), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_bubble", 32'(id_valid), 32'd0);
    ticks(2);
    chk_head("flush_target", 32'h40);
    ticks(5);
    chk_head("after_flush", 32'h54);

    // Backpressure for four cycles.
    stall_id = 1'b1;
    #1;
    chk("bp_pc_stall", 32'(pc_stall), 32'd1);
    ticks(4);
    chk_head("bp_hold", 32'h54);
    stall_id = 1'b0;
    tick();
    chk_head("bp_resume1", 32'h58);
    tick();
    chk_head("bp_resume2", 32'h5C);

    // Fill the FIFO under stall, then flush while stall_id stays high.
    stall_id = 1'b1;
    ticks(2);
    flush = 1'b1; target = 32'h80;
    #1;
    chk("flush_full_pc_stall", 32'(pc_stall), 32'd0);
    tick();
    flush = 1'b0; stall_id = 1'b0;
    chk("flush_full_empty", 32'(id_valid), 32'd0);
    ticks(2);
    chk_head("flush_full_target", 32'h80);
    ticks(3);
    chk_head("pre_reset", 32'h8C);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    q_pc.delete(); q_inst.delete();
    m_pend = 1'b0; pc_in = 32'd0;
    ticks(3);
    rst = 1'b1;
    ticks(2);
    chk_head("restart", 32'h0);
    ticks(4);
    chk_head("restart_run", 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
